// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_serializer
// Brief   : FIFO-buffered UART transmitter with a fully registered pad drive.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int log2_fifo = 2
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [15:0]          i_scaler,
    input  logic                 i_parity_en,
    input  logic                 i_stop2,
    input  logic                 i_wr_valid,
    input  logic [7:0]           i_wr_data,
    output logic                 o_wr_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic [log2_fifo:0]   o_fifo_count
);

    localparam int c_DEPTH = 2 ** log2_fifo;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [7:0]           r_mem [c_DEPTH];
    logic [log2_fifo-1:0] r_wr_ptr;
    logic [log2_fifo-1:0] r_rd_ptr;
    logic [log2_fifo:0]   r_count;

    logic [2:0]  r_state;
    logic [7:0]  r_shift;
    logic [15:0] r_baud;
    logic [15:0] r_scaler;
    logic        r_par_en;
    logic        r_stop2;
    logic [2:0]  r_bit_idx;
    logic        r_parity;
    logic        r_stop_idx;
    logic        r_tx;

    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_fifo_nempty;
    logic w_bit_end;
    logic w_last_stop;

    // Count never exceeds the depth, so its MSB alone flags "full".
    assign w_ready       = ~r_count[log2_fifo];
    assign w_push        = i_wr_valid & w_ready;
    assign w_fifo_nempty = |r_count;
    assign w_bit_end     = (r_baud == 16'd0);
    assign w_last_stop   = r_stop_idx | ~r_stop2;

    // A new frame starts from IDLE, or straight out of the final stop bit.
    assign w_pop = w_fifo_nempty &
                   ((r_state == c_IDLE) |
                    ((r_state == c_STOP) & w_bit_end & w_last_stop));

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + log2_fifo'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + log2_fifo'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (log2_fifo + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (log2_fifo + 1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state    <= c_IDLE;
            r_shift    <= '0;
            r_baud     <= '0;
            r_scaler   <= '0;
            r_par_en   <= 1'b0;
            r_stop2    <= 1'b0;
            r_bit_idx  <= '0;
            r_parity   <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
        end else if (w_pop) begin
            // Configuration is frozen here for the whole frame.
            r_shift    <= r_mem[r_rd_ptr];
            r_scaler   <= i_scaler;
            r_baud     <= i_scaler;
            r_par_en   <= i_parity_en;
            r_stop2    <= i_stop2;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b0;
            r_state    <= c_START;
        end else if (r_state != c_IDLE && !w_bit_end) begin
            r_baud <= r_baud - 16'd1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_tx <= 1'b1;
                end
                c_START: begin
                    r_baud    <= r_scaler;
                    r_tx      <= r_shift[0];
                    r_parity  <= r_shift[0];
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_idx <= 3'd0;
                    r_state   <= c_DATA;
                end
                c_DATA: begin
                    r_baud <= r_scaler;
                    if (r_bit_idx == 3'd7) begin
                        r_stop_idx <= 1'b0;
                        if (r_par_en) begin
                            r_tx    <= r_parity;
                            r_state <= c_PARITY;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= c_STOP;
                        end
                    end else begin
                        r_tx      <= r_shift[0];
                        r_parity  <= r_parity ^ r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                c_PARITY: begin
                    r_baud     <= r_scaler;
                    r_tx       <= 1'b1;
                    r_stop_idx <= 1'b0;
                    r_state    <= c_STOP;
                end
                c_STOP: begin
                    r_tx <= 1'b1;
                    if (!w_last_stop) begin
                        r_baud     <= r_scaler;
                        r_stop_idx <= 1'b1;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign o_tx         = r_tx;
    assign o_wr_ready   = w_ready;
    assign o_busy       = (r_state != c_IDLE) | w_fifo_nempty;
    assign o_fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// Testbench for uart_tx_serializer: queue/line-schedule reference model
// compared every cycle, plus literal frame expectations and random traffic.
module tb_uart_tx_serializer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] scaler = 16'd3;
    logic        parity_en = 1'b0;
    logic        stop2 = 1'b0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_ready;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];     // model FIFO contents
    bit         line[$];   // expected line level for each upcoming cycle
    bit         exp_tx = 1'b1;
    bit         exp_busy = 1'b0;
    bit         smp[$];

    uart_tx_serializer #(.log2_fifo(2)) dut (
        .i_clk        (clk),
        .i_nrst       (rst_n),
        .i_scaler     (scaler),
        .i_parity_en  (parity_en),
        .i_stop2      (stop2),
        .i_wr_valid   (wr_valid),
        .i_wr_data    (wr_data),
        .o_wr_ready   (wr_ready),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Append one whole frame, each bit repeated for its bit period.
    function automatic void gen_frame(input logic [7:0] b, input int sc, input bit pe, input bit s2);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (pe) bits.push_back(^b);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[j]) begin
            for (int k = 0; k <= sc; k++) line.push_back(bits[j]);
        end
    endfunction

    task automatic model_step();
        bit do_pop;
        bit do_push;
        if (!rst_n) begin
            mq.delete();
            line.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end else begin
            do_pop  = (line.size() == 0) && (mq.size() != 0);
            do_push = wr_valid && (mq.size() < DEPTH);
            if (do_pop) gen_frame(mq.pop_front(), int'(scaler), parity_en, stop2);
            if (do_push) mq.push_back(wr_data);
            if (line.size() != 0) begin
                exp_tx   = line.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
            if (mq.size() != 0) exp_busy = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("tx", tx, exp_tx);
            check("busy", busy, exp_busy);
            check("wr_ready", wr_ready, mq.size() < DEPTH);
            check("fifo_count", fifo_count, mq.size());
        end
    end

    task automatic sample(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            smp.push_back(tx);
        end
    endtask

    task automatic drain();
        int w = 0;
        while (busy && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("drain_busy", busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t got timeout expected finish", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] v;
        int          nbad;
        int          w;
        bit          e;

        // Reset then idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_tx", tx, 1'b1);
        check("idle_count", fifo_count, 3'd0);

        // Single frame 8'hA5, scaler 3, no parity, one stop bit
        scaler = 16'd3; parity_en = 1'b0; stop2 = 1'b0;
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_valid = 1'b0;
        check("a5_pre_fall", tx, 1'b1);
        smp.delete();
        sample(40);
        v = '0;
        for (int i = 0; i < 40; i++) v = {v[62:0], smp[i]};
        check("a5_frame", v, 64'h0F_0F00_F0FF);
        check("a5_busy_last", busy, 1'b1);
        @(posedge clk);
        #1;
        check("a5_busy_drop", busy, 1'b0);

        // Parity and two stop bits, scaler 0: 8'h07 then 8'h03 back-to-back
        @(negedge clk);
        scaler = 16'd0; parity_en = 1'b1; stop2 = 1'b1;
        wr_valid = 1'b1; wr_data = 8'h07;
        @(negedge clk);
        wr_data = 8'h03;
        smp.delete();
        fork
            sample(24);
            begin
                @(negedge clk);
                wr_valid = 1'b0;
            end
        join
        v = '0;
        for (int i = 0; i < 24; i++) v = {v[62:0], smp[i]};
        check("par_frames", v, 64'h707603);

        // Back-to-back writes into a full FIFO, scaler 1
        drain();
        scaler = 16'd1; parity_en = 1'b0; stop2 = 1'b0;
        wr_valid = 1'b1; wr_data = 8'h10;
        @(negedge clk);
        wr_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h11 + 8'(k);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("full_count", fifo_count, 3'd4);
        check("full_ready", wr_ready, 1'b0);
        w = 0;
        while (!wr_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_back", wr_ready, 1'b1);
        check("after_pop_count", fifo_count, 3'd3);
        wr_valid = 1'b1; wr_data = 8'h15;
        @(negedge clk);
        wr_valid = 1'b0;
        check("refill_count", fifo_count, 3'd4);

        // Mid-frame scaler change: 3-cycle bits then 6-cycle bits
        drain();
        scaler = 16'd2;
        wr_valid = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        smp.delete();
        fork
            sample(90);
            begin
                @(negedge clk);
                wr_valid = 1'b0;
                repeat (5) @(negedge clk);
                scaler = 16'd5;
            end
        join
        nbad = 0;
        for (int i = 0; i < 90; i++) begin
            e = !((i < 3) || (i >= 30 && i < 36));
            if (smp[i] != e) nbad++;
        end
        check("scaler_change_bad_cycles", nbad, 0);

        // Reset during the 4th data bit with two bytes queued
        drain();
        scaler = 16'd3;
        wr_valid = 1'b1; wr_data = 8'h00;
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        repeat (16) @(posedge clk);
        #3;
        check("pre_reset_tx", tx, 1'b0);
        check("pre_reset_count", fifo_count, 3'd2);
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", tx, 1'b1);
        check("async_reset_count", fifo_count, 3'd0);
        check("async_reset_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("post_reset_busy", busy, 1'b0);

        // Randomized traffic and configuration changes
        for (int c = 0; c < 3000; c++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_data  = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                scaler    = 16'($urandom_range(0, 3));
                parity_en = 1'($urandom);
                stop2     = 1'($urandom);
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        drain();
        check("final_tx", tx, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
